pio_mem_bridge: RTL and testbench

- Upstream PIO front end for a bank of pio_mem_wo-style targets.
- Accepts one host PIO transaction at a time and decodes the target from address bits.
- Issues the single-cycle reg_ms/reg_rd/reg_wr strobes to that target, then waits for its level mem_ack, which changes only on clk_div.
- Returns rdata/ack/error to the host; timeout and drain logic guarantee no lost or stale acks.

---
 rtl/pio_mem_bridge_pkg.sv | 21 ++
 rtl/pio_rdata_mux.sv | 20 ++
 rtl/pio_mem_bridge.sv | 159 +++++++++++++++
 tb/tb_pio_mem_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_mem_bridge_pkg.sv
// Shared definitions for the PIO-to-memory-target bridge: bus width,
// error read pattern, FSM encoding and the latched host request.
package pio_mem_bridge_pkg;

  localparam int PIO_NBITS = 32;
  localparam logic [PIO_NBITS-1:0] PIO_ERR_RDATA = '1;

  typedef enum logic [1:0] {
    PIO_BR_IDLE  = 2'd0,
    PIO_BR_ISSUE = 2'd1,
    PIO_BR_WAIT  = 2'd2,
    PIO_BR_DRAIN = 2'd3
  } pio_br_state_e;

  typedef struct packed {
    logic                 rd;
    logic [PIO_NBITS-1:0] addr;
    logic [PIO_NBITS-1:0] wdata;
  } pio_req_t;

endpackage

// File: rtl/pio_rdata_mux.sv
// Combinational NUM_TGT-way select of the flattened per-target read data.
module pio_rdata_mux
  import pio_mem_bridge_pkg::*;
#(
  parameter int NUM_TGT   = 4,
  parameter int TGT_NBITS = 2
) (
  input  logic [NUM_TGT*PIO_NBITS-1:0] mem_rdata_i,
  input  logic [TGT_NBITS-1:0]         sel_i,
  output logic [PIO_NBITS-1:0]         rdata_o
);

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel_i == TGT_NBITS'(i)) rdata_o = mem_rdata_i[i*PIO_NBITS +: PIO_NBITS];
    end
  end

endmodule

// File: rtl/pio_mem_bridge.sv
// Single-outstanding host PIO front end: decodes a target, issues a one-cycle
// strobe, waits for its level ack (or times out) and drains before re-arming.
module pio_mem_bridge
  import pio_mem_bridge_pkg::*;
#(
  parameter int NUM_TGT       = 4,
  parameter int TGT_NBITS     = 2,
  parameter int TGT_SEL_LSB   = 12,
  parameter int TIMEOUT_NBITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_div,
  input  logic                         host_req,
  input  logic                         host_rd,
  input  logic [PIO_NBITS-1:0]         host_addr,
  input  logic [PIO_NBITS-1:0]         host_wdata,
  output logic                         host_ack,
  output logic                         host_err,
  output logic [PIO_NBITS-1:0]         host_rdata,
  output logic [PIO_NBITS-1:0]         reg_addr,
  output logic [PIO_NBITS-1:0]         reg_din,
  output logic                         reg_rd,
  output logic                         reg_wr,
  output logic [NUM_TGT-1:0]           reg_ms,
  input  logic [NUM_TGT-1:0]           mem_ack,
  input  logic [NUM_TGT*PIO_NBITS-1:0] mem_rdata
);

  pio_br_state_e            state_q, state_d;
  pio_req_t                 req_q, req_d;
  logic [TGT_NBITS-1:0]     sel_q, sel_d;
  logic [TIMEOUT_NBITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic                     tick_q, tick_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [PIO_NBITS-1:0]     rdata_q, rdata_d;

  logic [TGT_NBITS-1:0]     in_sel;
  logic                     in_ok, in_ack, sel_ack, to_hit;
  logic [PIO_NBITS-1:0]     mux_rdata;

  // Out-of-range selects read as "no ack" so a decode error can still drain.
  function automatic logic ack_of(input logic [NUM_TGT-1:0] acks,
                                  input logic [TGT_NBITS-1:0] s);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (s == TGT_NBITS'(i)) r = acks[i];
    end
    return r;
  endfunction

  assign in_sel  = host_addr[TGT_SEL_LSB +: TGT_NBITS];
  assign in_ok   = int'(in_sel) < NUM_TGT;
  assign in_ack  = ack_of(mem_ack, in_sel);
  assign sel_ack = ack_of(mem_ack, sel_q);
  assign cnt_inc = cnt_q + 1'b1;
  assign to_hit  = &cnt_inc;

  pio_rdata_mux #(
    .NUM_TGT  (NUM_TGT),
    .TGT_NBITS(TGT_NBITS)
  ) u_rdata_mux (
    .mem_rdata_i(mem_rdata),
    .sel_i      (sel_q),
    .rdata_o    (mux_rdata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    reg_rd  = 1'b0;
    reg_wr  = 1'b0;
    reg_ms  = '0;
    case (state_q)
      PIO_BR_IDLE: begin
        if (host_req) begin
          if (!in_ok) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = PIO_ERR_RDATA;
            sel_d   = in_sel;
            state_d = PIO_BR_DRAIN;
          end else if (!in_ack) begin
            req_d   = '{rd: host_rd, addr: host_addr, wdata: host_wdata};
            sel_d   = in_sel;
            cnt_d   = '0;
            tick_d  = 1'b0;
            state_d = PIO_BR_ISSUE;
          end
        end
      end
      PIO_BR_ISSUE: begin
        reg_ms  = NUM_TGT'(1) << sel_q;
        reg_rd  = req_q.rd;
        reg_wr  = ~req_q.rd;
        cnt_d   = cnt_inc;
        tick_d  = tick_q | clk_div;
        state_d = PIO_BR_WAIT;
      end
      PIO_BR_WAIT: begin
        cnt_d  = to_hit ? cnt_q : cnt_inc;
        tick_d = tick_q | clk_div;
        if (sel_ack) begin
          ack_d   = 1'b1;
          err_d   = 1'b0;
          rdata_d = req_q.rd ? mux_rdata : '0;
          state_d = PIO_BR_DRAIN;
        end else if (to_hit && (tick_q || clk_div)) begin
          // A target that never saw a clk_div tick cannot have acked yet.
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = PIO_ERR_RDATA;
          state_d = PIO_BR_DRAIN;
        end
      end
      PIO_BR_DRAIN: begin
        if (!host_req && !sel_ack) state_d = PIO_BR_IDLE;
      end
      default: state_d = PIO_BR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PIO_BR_IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign host_ack   = ack_q;
  assign host_err   = err_q;
  assign host_rdata = rdata_q;
  assign reg_addr   = req_q.addr;
  assign reg_din    = req_q.wdata;

endmodule

// File: tb/tb_pio_mem_bridge.sv
// Bench for pio_mem_bridge with three modelled targets acking on clk_div ticks.
module tb_pio_mem_bridge;

  localparam int NT  = 3;
  localparam int LIM = 400;

  logic        clk = 1'b0;
  logic        rst, clk_div, host_req, host_rd;
  logic [31:0] host_addr, host_wdata, host_rdata, reg_addr, reg_din;
  logic        host_ack, host_err, reg_rd, reg_wr;
  logic [NT-1:0]    reg_ms, mem_ack, mute, late, pend;
  logic [NT*32-1:0] mem_rdata;
  logic [31:0] tgt_data [NT];
  logic [1:0]  divcnt;
  int vec, errs, late_clear_t;

  typedef struct {
    int          strb_n, strb_t, ack_t, mack_t, addr_bad, x_strb, x_ack;
    logic [31:0] rdata, rdata_after, s_addr, s_din;
    logic        err, s_rd;
    logic [NT-1:0] s_ms;
  } res_t;

  pio_mem_bridge #(
    .NUM_TGT(NT), .TGT_NBITS(2), .TGT_SEL_LSB(12), .TIMEOUT_NBITS(8)
  ) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div),
    .host_req(host_req), .host_rd(host_rd), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // clk_div: one-cycle tick every 4 clk
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      divcnt  <= '0;
      clk_div <= 1'b0;
    end else begin
      divcnt  <= divcnt + 2'd1;
      clk_div <= (divcnt == 2'd3);
    end
  end

  // Target model: a strobe arms a reply that appears as a level ack on the next tick
  // and lasts one tick period; 'late' forces the ack high, 'mute' ignores strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack <= '0;
      pend    <= '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (clk_div) begin
          mem_ack[i] <= pend[i] | late[i];
          if (pend[i]) pend[i] <= 1'b0;
        end
        if (reg_ms[i] && (reg_rd || reg_wr) && !mute[i]) pend[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < NT; i++) mem_rdata[i*32 +: 32] = tgt_data[i];
  end

  task automatic run_txn(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                         input int hold, output res_t r);
    logic [1:0] s;
    s = a[13:12];
    r = '{default: 0};
    r.strb_t = -1; r.ack_t = -1; r.mack_t = -1;
    repeat (10) @(negedge clk);
    host_req = 1'b1; host_rd = rd; host_addr = a; host_wdata = wd;
    for (int t = 1; t <= LIM; t++) begin
      @(negedge clk);
      if (t == late_clear_t) late = '0;
      if (reg_rd || reg_wr) begin
        r.strb_n++; r.strb_t = t; r.s_ms = reg_ms; r.s_addr = reg_addr;
        r.s_din = reg_din; r.s_rd = reg_rd;
      end
      if (r.strb_n > 0 && reg_addr !== a) r.addr_bad++;
      if (r.strb_n > 0 && r.mack_t < 0 && s != 2'd3 && mem_ack[s] === 1'b1) r.mack_t = t;
      if (host_ack === 1'b1) begin
        r.ack_t = t; r.rdata = host_rdata; r.err = host_err;
        break;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (reg_rd || reg_wr) r.x_strb++;
      if (host_ack) r.x_ack++;
    end
    r.rdata_after = host_rdata;
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec++;
    if ({host_ack, host_err, host_rdata, reg_addr, reg_din, reg_rd, reg_wr, reg_ms} !== '0) begin
      errs++; $display("FAIL reset_outputs got ack=%0b err=%0b rdata=%h addr=%h din=%h rd=%0b wr=%0b ms=%b exp all 0",
        host_ack, host_err, host_rdata, reg_addr, reg_din, reg_rd, reg_wr, reg_ms);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_tgt1();
    res_t r;
    run_txn(32'h1008, 1'b0, 32'hABCD, 0, r);
    vec++; if (r.strb_n != 1) begin errs++; $display("FAIL wr1_strobes got=%0d exp=1", r.strb_n); end
    vec++; if (r.strb_t != 1) begin errs++; $display("FAIL wr1_strobe_cycle got=%0d exp=1", r.strb_t); end
    vec++; if (r.s_ms !== 3'b010 || r.s_rd !== 1'b0) begin errs++; $display("FAIL wr1_ms_rd got=%b/%0b exp=010/0", r.s_ms, r.s_rd); end
    vec++; if (r.s_addr !== 32'h1008 || r.s_din !== 32'hABCD) begin errs++; $display("FAIL wr1_addr_din got=%h/%h exp=00001008/0000abcd", r.s_addr, r.s_din); end
    vec++; if (r.err !== 1'b0 || r.rdata !== 32'h0) begin errs++; $display("FAIL wr1_resp got err=%0b rdata=%h exp 0/0", r.err, r.rdata); end
    vec++; if (r.mack_t < 0 || r.ack_t != r.mack_t + 1) begin errs++; $display("FAIL wr1_ack_lat got ack_t=%0d mack_t=%0d exp ack_t=mack_t+1", r.ack_t, r.mack_t); end
    vec++; if (r.ack_t - r.strb_t > 7) begin errs++; $display("FAIL wr1_latency got=%0d exp<=7", r.ack_t - r.strb_t); end
  endtask

  task automatic test_read_tgt2();
    res_t r;
    tgt_data[2] = 32'h12345;
    run_txn(32'h2004, 1'b1, $urandom(), 0, r);
    vec++; if (r.rdata !== 32'h12345 || r.err !== 1'b0) begin errs++; $display("FAIL rd2_resp got rdata=%h err=%0b exp 00012345/0", r.rdata, r.err); end
    vec++; if (r.strb_n != 1 || r.s_rd !== 1'b1 || r.s_ms !== 3'b100) begin errs++; $display("FAIL rd2_strobe got n=%0d rd=%0b ms=%b exp 1/1/100", r.strb_n, r.s_rd, r.s_ms); end
    vec++; if (r.addr_bad != 0) begin errs++; $display("FAIL rd2_addr_stable got %0d unstable cycles exp 0", r.addr_bad); end
  endtask

  task automatic test_decode_err();
    res_t r;
    run_txn(32'h3000, 1'b1, 32'h0, 0, r);
    vec++; if (r.strb_n != 0) begin errs++; $display("FAIL dec_strobes got=%0d exp=0", r.strb_n); end
    vec++; if (r.err !== 1'b1 || r.rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dec_resp got err=%0b rdata=%h exp 1/ffffffff", r.err, r.rdata); end
    vec++; if (r.ack_t != 1) begin errs++; $display("FAIL dec_ack_cycle got=%0d exp=1", r.ack_t); end
  endtask

  task automatic test_timeout_late_ack();
    res_t r;
    mute[1] = 1'b1;
    run_txn(32'h1010, 1'b1, 32'h0, 0, r);
    vec++; if (r.err !== 1'b1 || r.rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL to_resp got err=%0b rdata=%h exp 1/ffffffff", r.err, r.rdata); end
    vec++; if (r.strb_t < 0 || r.ack_t - r.strb_t != 255) begin errs++; $display("FAIL to_cycles got=%0d exp=255", r.ack_t - r.strb_t); end
    mute[1] = 1'b0;
    late[1] = 1'b1;
    tgt_data[1] = $urandom();
    late_clear_t = 12;
    run_txn(32'h1014, 1'b1, 32'h0, 0, r);
    late_clear_t = -1;
    vec++; if (r.strb_t <= 12) begin errs++; $display("FAIL late_held got strobe_t=%0d exp>12", r.strb_t); end
    vec++; if (r.err !== 1'b0 || r.rdata !== tgt_data[1]) begin errs++; $display("FAIL late_resp got err=%0b rdata=%h exp 0/%h", r.err, r.rdata, tgt_data[1]); end
  endtask

  task automatic test_req_hold();
    res_t r;
    tgt_data[0] = $urandom();
    run_txn(32'h0040, 1'b1, 32'h0, 5, r);
    vec++; if (r.x_strb != 0 || r.x_ack != 0) begin errs++; $display("FAIL hold_single got extra strobes=%0d acks=%0d exp 0/0", r.x_strb, r.x_ack); end
    vec++; if (r.rdata_after !== tgt_data[0] || r.rdata !== tgt_data[0]) begin errs++; $display("FAIL hold_rdata got=%h/%h exp=%h", r.rdata, r.rdata_after, tgt_data[0]); end
    run_txn(32'h0044, 1'b0, 32'h55AA, 0, r);
    vec++; if (r.strb_n != 1 || r.err !== 1'b0 || r.strb_t != 1) begin errs++; $display("FAIL hold_next got n=%0d err=%0b t=%0d exp 1/0/1", r.strb_n, r.err, r.strb_t); end
  endtask

  task automatic test_reset_mid();
    res_t r;
    int acks;
    acks = 0;
    mute[2] = 1'b1;
    repeat (10) @(negedge clk);
    host_req = 1'b1; host_rd = 1'b1; host_addr = 32'h2000; host_wdata = 32'h0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    vec++;
    if ({host_ack, host_err, host_rdata, reg_addr, reg_din, reg_rd, reg_wr, reg_ms} !== '0) begin
      errs++; $display("FAIL rstmid_outputs got ack=%0b addr=%h rd=%0b ms=%b exp all 0", host_ack, reg_addr, reg_rd, reg_ms);
    end
    host_req = 1'b0;
    mute = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      if (host_ack) acks++;
    end
    vec++; if (acks != 0) begin errs++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
    tgt_data[2] = $urandom();
    run_txn(32'h2008, 1'b1, 32'h0, 0, r);
    vec++; if (r.strb_n != 1 || r.err !== 1'b0 || r.rdata !== tgt_data[2]) begin errs++; $display("FAIL rstmid_fresh got n=%0d err=%0b rdata=%h exp 1/0/%h", r.strb_n, r.err, r.rdata, tgt_data[2]); end
  endtask

  task automatic test_random();
    res_t r;
    logic [31:0] a, wd, exp_rd;
    logic [NT-1:0] exp_ms;
    logic rd;
    int s;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NT; i++) tgt_data[i] = $urandom();
      s = $urandom_range(0, 3);
      a = $urandom();
      a[13:12] = 2'(s);
      wd = $urandom();
      rd = 1'($urandom_range(0, 1));
      run_txn(a, rd, wd, 0, r);
      if (s >= NT) begin
        vec++; if (r.err !== 1'b1 || r.rdata !== 32'hFFFF_FFFF || r.strb_n != 0 || r.ack_t != 1) begin
          errs++; $display("FAIL rnd%0d_decode got err=%0b rdata=%h n=%0d t=%0d exp 1/ffffffff/0/1", n, r.err, r.rdata, r.strb_n, r.ack_t);
        end
      end else begin
        exp_rd = rd ? tgt_data[s] : 32'h0;
        exp_ms = NT'(1) << s;
        vec++; if (r.err !== 1'b0 || r.rdata !== exp_rd) begin errs++; $display("FAIL rnd%0d_resp got err=%0b rdata=%h exp 0/%h", n, r.err, r.rdata, exp_rd); end
        vec++; if (r.strb_n != 1 || r.strb_t != 1 || r.s_ms !== exp_ms || r.s_rd !== rd || r.s_addr !== a) begin
          errs++; $display("FAIL rnd%0d_strobe got n=%0d t=%0d ms=%b rd=%0b addr=%h exp 1/1/%b/%0b/%h", n, r.strb_n, r.strb_t, r.s_ms, r.s_rd, r.s_addr, exp_ms, rd, a);
        end
        if (!rd) begin
          vec++; if (r.s_din !== wd) begin errs++; $display("FAIL rnd%0d_din got=%h exp=%h", n, r.s_din, wd); end
        end
        vec++; if (r.mack_t < 0 || r.ack_t != r.mack_t + 1) begin errs++; $display("FAIL rnd%0d_ack_lat got ack_t=%0d mack_t=%0d", n, r.ack_t, r.mack_t); end
      end
    end
  endtask

  initial begin
    vec = 0; errs = 0; late_clear_t = -1;
    rst = 1'b1; host_req = 1'b0; host_rd = 1'b0; host_addr = '0; host_wdata = '0;
    mute = '0; late = '0;
    for (int i = 0; i < NT; i++) tgt_data[i] = '0;
    test_reset();
    test_write_tgt1();
    test_read_tgt2();
    test_decode_err();
    test_timeout_late_ack();
    test_req_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
